// File: rtl/lsu_wb_master_if.sv
// Classic Wishbone data bus between the LSU bridge (master) and WB data slaves.
// Signal names follow the master's view of the bus.
interface lsu_wb_master_if;
   logic        cyc_o;
   logic        stb_o;
   logic [31:0] adr_o;
   logic        we_o;
   logic [3:0]  sel_o;
   logic [31:0] dat_o;
   logic [31:0] dat_i;
   logic        ack_i;

   modport master (
      output cyc_o, stb_o, adr_o, we_o, sel_o, dat_o,
      input  dat_i, ack_i
   );

   modport slave (
      input  cyc_o, stb_o, adr_o, we_o, sel_o, dat_o,
      output dat_i, ack_i
   );
endinterface

// File: rtl/lsu_wb_master.sv
// Load/store unit to Wishbone bridge: one request -> one classic WB cycle -> one response.
// Handles lane select, store replication, load extraction/extension, misalignment and ack timeout.
module lsu_wb_master #(
   parameter int unsigned ACK_TIMEOUT = 16
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic            req_we_i,
   input  logic [31:0]     req_addr_i,
   input  logic [1:0]      req_size_i,
   input  logic            req_unsigned_i,
   input  logic [31:0]     req_wdata_i,
   output logic            rsp_valid_o,
   output logic [31:0]     rsp_rdata_o,
   output logic            rsp_err_o,
   lsu_wb_master_if.master wb
);

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   // Counter only needs to reach ACK_TIMEOUT-1; the abort fires on the cycle it sits there.
   localparam int unsigned TMR_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
   localparam bit TMR_EN = (ACK_TIMEOUT != 0);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUS,
      ST_RESP
   } state_t;

   state_t            state_reg;
   logic              cyc_reg;
   logic              we_reg;
   logic [31:0]       adr_reg;
   logic [3:0]        sel_reg;
   logic [31:0]       dat_reg;
   logic [1:0]        lane_reg;
   logic [1:0]        size_reg;
   logic              uns_reg;
   logic [TMR_W-1:0]  tmr_reg;
   logic              rsp_valid_reg;
   logic              rsp_err_reg;
   logic [31:0]       rsp_rdata_reg;

   logic              req_bad;
   logic [3:0]        sel_next;
   logic [31:0]       wdata_next;
   logic [7:0]        rd_lane [4];
   logic [7:0]        rd_byte;
   logic [15:0]       rd_half;
   logic [31:0]       load_ext;

   assign req_bad = (req_size_i == 2'b11)
                 || (req_size_i == SIZE_HALF && req_addr_i[0])
                 || (req_size_i == SIZE_WORD && req_addr_i[1:0] != 2'b00);

   // Per-lane select, store replication and load lane slicing.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign sel_next[gi] = (req_size_i == SIZE_WORD)
                            || (req_size_i == SIZE_BYTE && req_addr_i[1:0] == 2'(gi))
                            || (req_size_i == SIZE_HALF && req_addr_i[1] == 1'(gi / 2));

         assign wdata_next[8*gi +: 8] = (req_size_i == SIZE_BYTE) ? req_wdata_i[7:0]
                                      : (req_size_i == SIZE_HALF) ? req_wdata_i[8*(gi%2) +: 8]
                                      : req_wdata_i[8*gi +: 8];

         assign rd_lane[gi] = wb.dat_i[8*gi +: 8];
      end
   endgenerate

   assign rd_byte = rd_lane[lane_reg];
   assign rd_half = lane_reg[1] ? wb.dat_i[31:16] : wb.dat_i[15:0];

   always_comb begin
      load_ext = wb.dat_i;
      case (size_reg)
         SIZE_BYTE: load_ext = {{24{~uns_reg & rd_byte[7]}}, rd_byte};
         SIZE_HALF: load_ext = {{16{~uns_reg & rd_half[15]}}, rd_half};
         default:   load_ext = wb.dat_i;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg     <= ST_IDLE;
         cyc_reg       <= 1'b0;
         we_reg        <= 1'b0;
         adr_reg       <= '0;
         sel_reg       <= '0;
         dat_reg       <= '0;
         lane_reg      <= '0;
         size_reg      <= '0;
         uns_reg       <= 1'b0;
         tmr_reg       <= '0;
         rsp_valid_reg <= 1'b0;
         rsp_err_reg   <= 1'b0;
         rsp_rdata_reg <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (req_valid_i) begin
                  lane_reg <= req_addr_i[1:0];
                  size_reg <= req_size_i;
                  uns_reg  <= req_unsigned_i;
                  we_reg   <= req_we_i;
                  tmr_reg  <= '0;
                  if (req_bad) begin
                     state_reg     <= ST_RESP;
                     rsp_valid_reg <= 1'b1;
                     rsp_err_reg   <= 1'b1;
                     rsp_rdata_reg <= '0;
                  end else begin
                     state_reg <= ST_BUS;
                     cyc_reg   <= 1'b1;
                     adr_reg   <= {req_addr_i[31:2], 2'b00};
                     sel_reg   <= sel_next;
                     dat_reg   <= wdata_next;
                  end
               end
            end

            ST_BUS: begin
               if (wb.ack_i) begin
                  state_reg     <= ST_RESP;
                  cyc_reg       <= 1'b0;
                  rsp_valid_reg <= 1'b1;
                  rsp_err_reg   <= 1'b0;
                  rsp_rdata_reg <= we_reg ? 32'h0 : load_ext;
               end else if (TMR_EN && tmr_reg == TMR_LAST) begin
                  state_reg     <= ST_RESP;
                  cyc_reg       <= 1'b0;
                  rsp_valid_reg <= 1'b1;
                  rsp_err_reg   <= 1'b1;
                  rsp_rdata_reg <= '0;
               end else begin
                  tmr_reg <= tmr_reg + 1'b1;
               end
            end

            ST_RESP: begin
               state_reg     <= ST_IDLE;
               rsp_valid_reg <= 1'b0;
               rsp_err_reg   <= 1'b0;
               rsp_rdata_reg <= '0;
            end

            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign req_ready_o = (state_reg == ST_IDLE);
   assign rsp_valid_o = rsp_valid_reg;
   assign rsp_err_o   = rsp_err_reg;
   assign rsp_rdata_o = rsp_rdata_reg;

   assign wb.cyc_o = cyc_reg;
   assign wb.stb_o = cyc_reg;
   assign wb.adr_o = adr_reg;
   assign wb.we_o  = we_reg;
   assign wb.sel_o = sel_reg;
   assign wb.dat_o = dat_reg;

endmodule

// File: tb/tb_lsu_wb_master.sv
// Scoreboard bench for lsu_wb_master against a one-cycle-ack data memory model.
module tb_lsu_wb_master;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_we_i;
   logic [31:0] req_addr_i;
   logic [1:0]  req_size_i;
   logic        req_unsigned_i;
   logic [31:0] req_wdata_i;
   logic        rsp_valid_o;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;

   lsu_wb_master_if wb_if ();

   lsu_wb_master #(.ACK_TIMEOUT(16)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .req_we_i       (req_we_i),
      .req_addr_i     (req_addr_i),
      .req_size_i     (req_size_i),
      .req_unsigned_i (req_unsigned_i),
      .req_wdata_i    (req_wdata_i),
      .rsp_valid_o    (rsp_valid_o),
      .rsp_rdata_o    (rsp_rdata_o),
      .rsp_err_o      (rsp_err_o),
      .wb             (wb_if)
   );

   always #5 clk_i = ~clk_i;

   int cyc_cnt = 0;
   always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

   // Data memory slave: ack one cycle after stb, writes on the acked edge.
   logic [31:0] mem [256];
   logic        slv_ack;
   bit          ack_en = 1'b1;

   assign wb_if.dat_i = mem[wb_if.adr_o[9:2]];
   assign wb_if.ack_i = slv_ack;

   always @(posedge clk_i) begin
      if (rst_i) begin
         slv_ack <= 1'b0;
         for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      end else begin
         slv_ack <= ack_en && wb_if.stb_o && !slv_ack;
         if (wb_if.stb_o && slv_ack && wb_if.we_o)
            for (int b = 0; b < 4; b++)
               if (wb_if.sel_o[b]) mem[wb_if.adr_o[9:2]][8*b +: 8] <= wb_if.dat_o[8*b +: 8];
      end
   end

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          at;
      int          gap;
   } rsp_t;

   typedef struct {
      logic [31:0] adr;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] dat;
      int          len;
   } bus_t;

   rsp_t rsp_q [$];
   bus_t bus_q [$];

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   // Response monitor
   int last_rsp = 0;
   always @(negedge clk_i) begin
      if (!rst_i && rsp_valid_o) begin
         if (rsp_q.size() == 0) begin
            chk("unexpected_rsp", 32'(rsp_valid_o), 32'h0);
         end else begin
            rsp_t e;
            e = rsp_q.pop_front();
            chk("rsp_rdata", rsp_rdata_o, e.rdata);
            chk("rsp_err", 32'(rsp_err_o), 32'(e.err));
            chk("rsp_cycle", 32'(cyc_cnt), 32'(e.at));
            chk("rsp_ready_low", 32'(req_ready_o), 32'h0);
            if (e.gap != 0) chk("rsp_spacing", 32'(cyc_cnt - last_rsp), 32'(e.gap));
         end
         $display("rsp @%0d: rdata=0x%08h err=%0b", cyc_cnt, rsp_rdata_o, rsp_err_o);
         last_rsp = cyc_cnt;
      end
   end

   // Bus monitor: checks the cycle's attributes on its first cycle and its length at the end.
   bit   in_bus = 1'b0;
   int   stb_len = 0;
   bus_t cur_bus;
   always @(negedge clk_i) begin
      if (wb_if.stb_o) begin
         chk("cyc_eq_stb", 32'(wb_if.cyc_o), 32'h1);
         if (!in_bus) begin
            in_bus  = 1'b1;
            stb_len = 1;
            if (bus_q.size() == 0) begin
               chk("unexpected_bus_cycle", 32'(wb_if.stb_o), 32'h0);
               cur_bus.len = 0;
            end else begin
               cur_bus = bus_q.pop_front();
               chk("adr_o", wb_if.adr_o, cur_bus.adr);
               chk("we_o", 32'(wb_if.we_o), 32'(cur_bus.we));
               chk("sel_o", 32'(wb_if.sel_o), 32'(cur_bus.sel));
               if (cur_bus.we) chk("dat_o", wb_if.dat_o, cur_bus.dat);
            end
         end else begin
            stb_len++;
         end
      end else if (in_bus) begin
         in_bus = 1'b0;
         if (cur_bus.len != 0) chk("stb_length", 32'(stb_len), 32'(cur_bus.len));
      end
   end

   // lat = edges from accept to response; also the expected stb length when nonzero.
   task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err, input int lat,
                        input logic [3:0] exp_sel, input logic [31:0] exp_dat,
                        input bit hold, input int gap);
      int w = 0;
      @(negedge clk_i);
      req_we_i       = we;
      req_addr_i     = addr;
      req_size_i     = size;
      req_unsigned_i = uns;
      req_wdata_i    = wdata;
      req_valid_i    = 1'b1;
      while (!req_ready_o && w < 200) begin
         @(negedge clk_i);
         w++;
      end
      if (!req_ready_o) begin
         chk("accept_timeout", 32'(req_ready_o), 32'h1);
         req_valid_i = 1'b0;
         return;
      end
      @(posedge clk_i);
      #1;
      rsp_q.push_back('{rdata: exp_rd, err: exp_err, at: cyc_cnt + lat, gap: gap});
      if (lat != 0)
         bus_q.push_back('{adr: {addr[31:2], 2'b00}, we: we, sel: exp_sel, dat: exp_dat, len: lat});
      if (!hold) req_valid_i = 1'b0;
   endtask

   task automatic drain();
      int w = 0;
      while ((rsp_q.size() != 0 || bus_q.size() != 0 || in_bus || !req_ready_o) && w < 200) begin
         @(negedge clk_i);
         w++;
      end
      chk("drain_done", 32'(rsp_q.size() + bus_q.size()), 32'h0);
   endtask

   initial begin
      rst_i          = 1'b1;
      req_valid_i    = 1'b0;
      req_we_i       = 1'b0;
      req_addr_i     = 32'h0;
      req_size_i     = 2'b00;
      req_unsigned_i = 1'b0;
      req_wdata_i    = 32'h0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      chk("reset_ready", 32'(req_ready_o), 32'h1);
      chk("reset_cyc", 32'(wb_if.cyc_o), 32'h0);
      chk("reset_stb", 32'(wb_if.stb_o), 32'h0);
      chk("reset_we", 32'(wb_if.we_o), 32'h0);
      chk("reset_rsp_valid", 32'(rsp_valid_o), 32'h0);
      chk("reset_rsp_err", 32'(rsp_err_o), 32'h0);
      chk("reset_rdata", rsp_rdata_o, 32'h0);
      chk("reset_adr", wb_if.adr_o, 32'h0);
      chk("reset_sel", 32'(wb_if.sel_o), 32'h0);
      chk("reset_dat", wb_if.dat_o, 32'h0);

      //     we    addr          sz     uns   wdata          exp_rd         err  lat sel      dat           hold gap
      issue(1'b1, 32'h0000_0103, 2'b00, 1'b0, 32'h1234_56AB, 32'h0000_0000, 1'b0, 2, 4'b1000, 32'hABAB_ABAB, 1'b0, 0);
      issue(1'b0, 32'h0000_0100, 2'b10, 1'b0, 32'h0,         32'hAB00_0000, 1'b0, 2, 4'b1111, 32'h0,        1'b0, 0);
      issue(1'b1, 32'h0000_0100, 2'b10, 1'b0, 32'h8001_1234, 32'h0000_0000, 1'b0, 2, 4'b1111, 32'h8001_1234, 1'b0, 0);
      issue(1'b0, 32'h0000_0102, 2'b01, 1'b0, 32'h0,         32'hFFFF_8001, 1'b0, 2, 4'b1100, 32'h0,        1'b0, 0);
      issue(1'b0, 32'h0000_0102, 2'b01, 1'b1, 32'h0,         32'h0000_8001, 1'b0, 2, 4'b1100, 32'h0,        1'b0, 0);
      issue(1'b0, 32'h0000_0101, 2'b00, 1'b0, 32'h0,         32'h0000_0012, 1'b0, 2, 4'b0010, 32'h0,        1'b0, 0);
      issue(1'b0, 32'h0000_0103, 2'b00, 1'b0, 32'h0,         32'hFFFF_FF80, 1'b0, 2, 4'b1000, 32'h0,        1'b0, 0);
      issue(1'b0, 32'h0000_0103, 2'b00, 1'b1, 32'h0,         32'h0000_0080, 1'b0, 2, 4'b1000, 32'h0,        1'b0, 0);
      issue(1'b1, 32'h0000_0100, 2'b01, 1'b0, 32'hFFFF_5678, 32'h0000_0000, 1'b0, 2, 4'b0011, 32'h5678_5678, 1'b0, 0);
      // Misaligned and illegal-size requests: immediate error, no bus cycle
      issue(1'b0, 32'h0000_0101, 2'b10, 1'b0, 32'h0,         32'h0,         1'b1, 0, 4'b0000, 32'h0,        1'b0, 0);
      issue(1'b0, 32'h0000_0103, 2'b01, 1'b0, 32'h0,         32'h0,         1'b1, 0, 4'b0000, 32'h0,        1'b0, 0);
      issue(1'b0, 32'h0000_0100, 2'b11, 1'b0, 32'h0,         32'h0,         1'b1, 0, 4'b0000, 32'h0,        1'b0, 0);
      issue(1'b1, 32'h0000_0102, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0,         1'b1, 0, 4'b0000, 32'h0,        1'b0, 0);
      drain();

      // Slave never acks: abort after 16 strobe cycles
      ack_en = 1'b0;
      issue(1'b0, 32'h0000_0200, 2'b10, 1'b0, 32'h0,         32'h0,         1'b1, 16, 4'b1111, 32'h0,       1'b0, 0);
      drain();
      ack_en = 1'b1;

      // Back-to-back with req_valid_i held high
      issue(1'b0, 32'h0000_0100, 2'b10, 1'b0, 32'h0,         32'h8001_5678, 1'b0, 2, 4'b1111, 32'h0,        1'b1, 0);
      issue(1'b0, 32'h0000_0100, 2'b01, 1'b1, 32'h0,         32'h0000_5678, 1'b0, 2, 4'b0011, 32'h0,        1'b1, 4);
      issue(1'b1, 32'h0000_0104, 2'b00, 1'b0, 32'h0000_005A, 32'h0000_0000, 1'b0, 2, 4'b0001, 32'h5A5A_5A5A, 1'b1, 4);
      issue(1'b0, 32'h0000_0104, 2'b10, 1'b0, 32'h0,         32'h0000_005A, 1'b0, 2, 4'b1111, 32'h0,        1'b0, 4);
      drain();

      // Reset held two cycles in the middle of a bus cycle
      ack_en = 1'b0;
      @(negedge clk_i);
      req_we_i    = 1'b0;
      req_addr_i  = 32'h0000_0100;
      req_size_i  = 2'b10;
      req_valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      bus_q.push_back('{adr: 32'h0000_0100, we: 1'b0, sel: 4'b1111, dat: 32'h0, len: 0});
      req_valid_i = 1'b0;
      repeat (2) @(negedge clk_i);
      chk("rst_pre_cyc", 32'(wb_if.cyc_o), 32'h1);
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      chk("rst_cyc_drop", 32'(wb_if.cyc_o), 32'h0);
      @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("rst_post_ready", 32'(req_ready_o), 32'h1);
      chk("rst_post_cyc", 32'(wb_if.cyc_o), 32'h0);
      chk("rst_post_rsp_valid", 32'(rsp_valid_o), 32'h0);
      repeat (20) @(negedge clk_i);
      chk("rst_no_late_cyc", 32'(wb_if.cyc_o), 32'h0);
      ack_en = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "global timeout");
   end

endmodule
